// File: rtl/uflash_page_writer.sv
// uflash_page_writer: erase-then-program sequencer for one uflash page.
// Enforces write/erase spacing and handshakes one word per flash write.
module uflash_page_writer #(
  parameter int CLK_FREQ = 5400000,
  parameter int GAP_MS   = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [5:0]  cmd_page,
  input  logic [9:0]  cmd_nwords,
  input  logic        wdata_valid,
  output logic        wdata_ready,
  input  logic [31:0] wdata,
  output logic        fl_sel,
  output logic [3:0]  fl_wstrb,
  output logic [14:0] fl_addr,
  output logic [31:0] fl_data,
  input  logic        fl_ready,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [63:0] GAP_W =
    64'(CLK_FREQ) * 64'(GAP_MS) / 64'd1000 + 64'd1;
  localparam logic [23:0] GAP_CLKS = GAP_W[23:0];
  localparam logic [23:0] GAP_LAST = GAP_CLKS - 24'd1;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    GAP_E,
    ERASE,
    GAP_P,
    FETCH,
    PROG,
    FINISH
  } state_t;

  state_t      state;
  logic [5:0]  page;
  logic [9:0]  nwords;
  logic [8:0]  idx;
  logic [23:0] since_prog;
  logic [23:0] gap_cnt;
  logic        prog_ack;
  logic [9:0]  idx_next;

  assign prog_ack = (state == PROG) && fl_sel && fl_ready;
  assign idx_next = {1'b0, idx} + 10'd1;

  // Cycles since the last completed program write, saturating at the gap.
  always_ff @(posedge clk) begin
    if (reset) begin
      since_prog <= GAP_CLKS;
    end else if (prog_ack) begin
      since_prog <= '0;
    end else if (since_prog != GAP_CLKS) begin
      since_prog <= since_prog + 24'd1;
    end
  end

  // Command sequencer with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cmd_ready   <= 1'b0;
      wdata_ready <= 1'b0;
      fl_sel      <= 1'b0;
      fl_wstrb    <= '0;
      fl_addr     <= '0;
      fl_data     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      page        <= '0;
      nwords      <= '0;
      idx         <= '0;
      gap_cnt     <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          if (cmd_valid && cmd_ready) begin
            page      <= cmd_page;
            nwords    <= cmd_nwords;
            err       <= 1'b0;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= CHECK;
          end
        end
        CHECK: begin
          if (page > 6'd37 || nwords > 10'd512) begin
            err   <= 1'b1;
            done  <= 1'b1;
            state <= FINISH;
          end else begin
            state <= GAP_E;
          end
        end
        GAP_E: begin
          if (since_prog == GAP_CLKS) begin
            fl_sel   <= 1'b1;
            fl_wstrb <= 4'b0001;
            fl_addr  <= {page, 9'd0};
            state    <= ERASE;
          end
        end
        ERASE: begin
          if (fl_ready) begin
            fl_sel <= 1'b0;
            if (nwords != 10'd0) begin
              gap_cnt <= '0;
              state   <= GAP_P;
            end else begin
              done  <= 1'b1;
              state <= FINISH;
            end
          end
        end
        GAP_P: begin
          if (gap_cnt == GAP_LAST) begin
            idx         <= '0;
            wdata_ready <= 1'b1;
            state       <= FETCH;
          end else begin
            gap_cnt <= gap_cnt + 24'd1;
          end
        end
        FETCH: begin
          if (wdata_valid) begin
            wdata_ready <= 1'b0;
            fl_data     <= wdata;
            fl_wstrb    <= 4'b1111;
            fl_addr     <= {page, idx};
            fl_sel      <= 1'b1;
            state       <= PROG;
          end
        end
        PROG: begin
          if (fl_ready) begin
            fl_sel <= 1'b0;
            idx    <= idx + 9'd1;
            if (idx_next == nwords) begin
              done  <= 1'b1;
              state <= FINISH;
            end else begin
              wdata_ready <= 1'b1;
              state       <= FETCH;
            end
          end
        end
        FINISH: begin
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
